hilo_muldiv_ctrl: RTL and testbench

// - Iterative multiply/divide sequencer for the EX stage; owns the HI/LO write path for
//   op_mult, op_multu, op_div and op_divu.
// - Runs a 32-step shift-add multiply or restoring divide.
// - Stalls the pipeline while busy, then pulses one HI/LO write.
// - Same whi/wlo/wHiData/wLoData contract as the EX outputs; sits between EX and the HI/LO regs.

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 35 +++
 rtl/hilo_muldiv_ctrl_if.sv | 36 +++
 rtl/hilo_muldiv_ctrl_muldiv_step.sv | 47 ++++
 rtl/hilo_muldiv_ctrl.sv | 152 +++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Package for the HI/LO multiply/divide sequencer.
// Holds the operation codes that can launch the sequencer, the FSM state
// encoding and small decode helpers shared by the top and the bench.
package hilo_muldiv_ctrl_pkg;

  // Default operand width. The iteration count equals the operand width.
  localparam int MD_WIDTH = 32;

  // Operation codes (function-field values of the HI/LO ops).
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1a;
  localparam logic [5:0] OP_DIVU  = 6'h1b;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIV  = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  function automatic logic op_valid(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_signed(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [5:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Bus between the EX stage and the multiply/divide sequencer.
// master = EX side (launches ops, consumes stall and HI/LO writes)
// slave  = sequencer
//
// Handshake: start_i is a request that is only taken while the sequencer is
// idle and op_i is a valid HI/LO op; there is no ready signal, acceptance is
// visible as stall_o going high in the same cycle. cancel_i aborts any op that
// has not yet reached its write cycle and blocks a launch in the same cycle.
// whi/wlo pulse together for exactly one cycle; wHiData/wLoData and dbz_o are
// meaningful in that cycle (the data stays stable until the next write).
interface hilo_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [5:0]       op_i;
  logic [WIDTH-1:0] regaData;
  logic [WIDTH-1:0] regbData;
  logic             cancel_i;
  logic             stall_o;
  logic             busy_o;
  logic             whi;
  logic             wlo;
  logic [WIDTH-1:0] wHiData;
  logic [WIDTH-1:0] wLoData;
  logic             dbz_o;

  modport master (
    output start_i, op_i, regaData, regbData, cancel_i,
    input  stall_o, busy_o, whi, wlo, wHiData, wLoData, dbz_o
  );

  modport slave (
    input  start_i, op_i, regaData, regbData, cancel_i,
    output stall_o, busy_o, whi, wlo, wHiData, wLoData, dbz_o
  );
endinterface

// File: rtl/hilo_muldiv_ctrl_muldiv_step.sv
// Single iteration of the multiply/divide datapath, purely combinational.
// Ports:
//   is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi_i    : accumulator (multiply) / partial remainder (divide)
//   lo_i    : multiplier bits (multiply) / dividend-quotient bits (divide)
//   opnd_i  : multiplicand (multiply) / divisor (divide)
//   hi_o, lo_o : register values after this step
module hilo_muldiv_ctrl_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;

  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    // Multiply: add multiplicand when the low multiplier bit is set, then
    // shift the {acc, mplr} pair right; the carry lands in acc's MSB.
    sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: the shifted remainder can need one extra bit, so compare at
    // WIDTH+1; the difference itself always fits in WIDTH bits.
    shifted = {hi_i, lo_i[WIDTH-1]};
    trial   = shifted[WIDTH-1:0] - opnd_i;
    if (is_div) begin
      if (shifted >= {1'b0, opnd_i}) begin
        hi_o = trial;
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = shifted[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO write path.
// Operands are taken as magnitudes, iterated one bit per cycle, then sign
// corrected and written to HI/LO with a one-cycle whi/wlo pulse.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : hilo_muldiv_ctrl_if.slave (launch, cancel, stall, HI/LO write)
//   dbg_state : current FSM state (md_state_e encoding)
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  hilo_muldiv_ctrl_if.slave        bus,
  output logic [2:0]               dbg_state
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state, state_n;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi_r, lo_r, opnd_r;
  logic             psign_r;   // product / quotient sign
  logic             rsign_r;   // remainder sign (sign of dividend)
  logic             dbz_r;
  logic             is_div_r;
  logic [WIDTH-1:0] whi_data_r, wlo_data_r;

  logic             launch, last_step, sgn, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod, prod_neg;

  // A launch needs a valid op and no simultaneous flush.
  assign launch    = (state == MD_IDLE) && bus.start_i && op_valid(bus.op_i) && !bus.cancel_i;
  assign last_step = (count == CW'(WIDTH - 1));
  assign sgn       = op_signed(bus.op_i);
  assign b_zero    = (bus.regbData == '0);
  assign a_mag     = (sgn && bus.regaData[WIDTH-1]) ? -bus.regaData : bus.regaData;
  assign b_mag     = (sgn && bus.regbData[WIDTH-1]) ? -bus.regbData : bus.regbData;

  hilo_muldiv_ctrl_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_r),
    .hi_i   (hi_r),
    .lo_i   (lo_r),
    .opnd_i (opnd_r),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Sign correction. The most-negative / -1 divide needs no special case:
  // its magnitude quotient is 2^(WIDTH-1) with a positive sign, remainder 0.
  always_comb begin
    prod     = {hi_r, lo_r};
    prod_neg = -prod;
    fix_hi   = hi_r;
    fix_lo   = lo_r;
    if (!is_div_r) begin
      {fix_hi, fix_lo} = psign_r ? prod_neg : prod;
    end else begin
      // On divide-by-zero hi_r holds |A|, so the remainder sign restores A.
      fix_hi = rsign_r ? -hi_r : hi_r;
      fix_lo = dbz_r ? '1 : (psign_r ? -lo_r : lo_r);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      MD_IDLE: begin
        if (launch) begin
          if (op_is_div(bus.op_i)) state_n = b_zero ? MD_FIX : MD_DIV;
          else                     state_n = MD_MUL;
        end
      end
      MD_MUL, MD_DIV: begin
        if (bus.cancel_i)   state_n = MD_IDLE;
        else if (last_step) state_n = MD_FIX;
      end
      MD_FIX:  state_n = bus.cancel_i ? MD_IDLE : MD_DONE;
      MD_DONE: state_n = MD_IDLE;
      default: state_n = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MD_IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      opnd_r     <= '0;
      psign_r    <= 1'b0;
      rsign_r    <= 1'b0;
      dbz_r      <= 1'b0;
      is_div_r   <= 1'b0;
      whi_data_r <= '0;
      wlo_data_r <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (launch) begin
            count    <= '0;
            is_div_r <= op_is_div(bus.op_i);
            dbz_r    <= op_is_div(bus.op_i) && b_zero;
            psign_r  <= sgn && (bus.regaData[WIDTH-1] ^ bus.regbData[WIDTH-1]);
            rsign_r  <= sgn && bus.regaData[WIDTH-1];
            if (op_is_div(bus.op_i)) begin
              hi_r   <= b_zero ? a_mag : '0;
              lo_r   <= a_mag;
              opnd_r <= b_mag;
            end else begin
              hi_r   <= '0;
              lo_r   <= b_mag;
              opnd_r <= a_mag;
            end
          end
        end
        MD_MUL, MD_DIV: begin
          hi_r  <= step_hi;
          lo_r  <= step_lo;
          count <= count + 1'b1;
        end
        MD_FIX: begin
          if (!bus.cancel_i) begin
            whi_data_r <= fix_hi;
            wlo_data_r <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // DONE is the write cycle; stall drops there so the next instruction moves.
  assign bus.stall_o = launch || (state == MD_MUL) || (state == MD_DIV) || (state == MD_FIX);
  assign bus.busy_o  = (state != MD_IDLE);
  assign bus.whi     = (state == MD_DONE);
  assign bus.wlo     = (state == MD_DONE);
  assign bus.dbz_o   = (state == MD_DONE) && dbz_r;
  assign bus.wHiData = whi_data_r;
  assign bus.wLoData = wlo_data_r;
  assign dbg_state   = state;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hilo_muldiv_ctrl_if #(.WIDTH(32)) bus ();
  logic [2:0] dbg_state;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the sequencer idle; returns at cycle 1.
  task automatic launch(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    bus.op_i     = op;
    bus.regaData = a;
    bus.regbData = b;
    bus.start_i  = 1'b1;
    #1;
    check({name, "_stall0"}, {63'd0, bus.stall_o}, 64'd1);
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // Waits (bounded) for the write pulse, starting at cycle start_cyc.
  task automatic wait_done(input string name, input int exp_lat, input logic exp_dbz,
                           input int start_cyc);
    int cyc = start_cyc;
    bit seen = 1'b0;
    int stall_low = 0;
    logic [63:0] exp_v;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    while (cyc <= 80 && !seen) begin
      if (bus.whi) seen = 1'b1;
      else begin
        if (!bus.stall_o) stall_low++;
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no whi expected whi by cycle %0d", name, exp_lat);
      return;
    end
    check({name, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({name, "_data"}, {bus.wHiData, bus.wLoData}, exp_v);
    check({name, "_flags"}, {61'd0, bus.wlo, bus.dbz_o, bus.stall_o}, {61'd0, 1'b1, exp_dbz, 1'b0});
    check({name, "_stall_busy"}, 64'(stall_low), 64'd0);
    @(negedge clk);
    check({name, "_pulse_end"}, {62'd0, bus.whi, bus.busy_o}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vecs[0]  = '{OP_MULT,  32'd3,         32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[3]  = '{OP_DIV,   32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[4]  = '{OP_DIVU,  32'h00001234,  32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 2};
    vecs[5]  = '{OP_MULTU, 32'h12345678,  32'h10,       32'h00000001, 32'h23456780, 1'b0, 34};
    vecs[6]  = '{OP_DIVU,  32'd100,       32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34};
    vecs[7]  = '{OP_DIV,   32'd7,         32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    vecs[8]  = '{OP_MULT,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFF8,  32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 2};
    vecs[10] = '{OP_DIVU,  32'hFFFFFFFF,  32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 34};
    vecs[11] = '{OP_MULT,  32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};

    bus.start_i  = 1'b0;
    bus.op_i     = '0;
    bus.regaData = '0;
    bus.regbData = '0;
    bus.cancel_i = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {58'd0, bus.whi, bus.wlo, bus.dbz_o, bus.busy_o, bus.stall_o, 1'b0}, 64'd0);
    check("reset_data", {bus.wHiData, bus.wLoData}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({vecs[i].hi, vecs[i].lo});
      launch($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].lat, vecs[i].dbz, 1);
    end

    // Invalid op never launches or stalls
    bus.op_i = 6'h20;
    bus.start_i = 1'b1;
    #1 check("invalid_stall", {63'd0, bus.stall_o}, 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    check("invalid_busy", {63'd0, bus.busy_o}, 64'd0);

    // cancel together with start in IDLE: cancel wins
    bus.op_i = OP_MULT;
    bus.start_i = 1'b1;
    bus.cancel_i = 1'b1;
    #1 check("cancel_start_stall", {63'd0, bus.stall_o}, 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.cancel_i = 1'b0;
    check("cancel_start_busy", {63'd0, bus.busy_o}, 64'd0);

    // cancel at cycle 10 of a mult: no write, HI/LO data untouched
    launch("cancel_mult", OP_MULT, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    bus.cancel_i = 1'b1;
    @(negedge clk);
    bus.cancel_i = 1'b0;
    check("cancel_busy", {63'd0, bus.busy_o}, 64'd0);
    begin
      int whi_seen = 0;
      for (int c = 0; c < 40; c++) begin
        if (bus.whi) whi_seen++;
        @(negedge clk);
      end
      check("cancel_no_whi", 64'(whi_seen), 64'd0);
    end
    check("cancel_data_kept", {bus.wHiData, bus.wLoData}, {vecs[11].hi, vecs[11].lo});

    // second start at cycle 5 of a div is ignored
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    launch("restart_div", OP_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (4) @(negedge clk);
    bus.op_i = OP_DIVU;
    bus.regaData = 32'd100;
    bus.regbData = 32'd7;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done("restart_div", 34, 1'b0, 6);

    // async reset at cycle 20 of a divu, then a fresh mult
    launch("rst_divu", OP_DIVU, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_ctrl", {59'd0, bus.whi, bus.wlo, bus.dbz_o, bus.busy_o, bus.stall_o}, 64'd0);
    check("midrst_data", {bus.wHiData, bus.wLoData}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
    launch("post_rst_mult", OP_MULT, 32'd3, 32'hFFFFFFFB);
    wait_done("post_rst_mult", 34, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
